// File: rtl/openhw_fifo_reader.sv
// Single-clock FIFO: enable-qualified write side, show-ahead valid/ready read side.
// Occupancy and flags are registered; ReadData is the head entry straight from storage.
module openhw_fifo_reader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     WriteEn,
  input  logic [WIDTH-1:0]         WriteData,
  output logic                     Full,
  output logic                     WriteDrop,
  output logic                     ReadValid,
  input  logic                     ReadReady,
  output logic [WIDTH-1:0]         ReadData,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr_next;
  logic [PW-1:0]    rptr_next;
  logic [PW-1:0]    count_next;
  logic             push_c;
  logic             pop_c;

  // Full blocks a push even when a pop happens in the same cycle (no pass-through).
  always_comb begin
    push_c     = WriteEn && !Full;
    pop_c      = ReadValid && ReadReady;
    wptr_next  = wptr + PW'(push_c);
    rptr_next  = rptr + PW'(pop_c);
    count_next = wptr_next - rptr_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      Count     <= '0;
      Empty     <= 1'b1;
      Full      <= 1'b0;
      ReadValid <= 1'b0;
      WriteDrop <= 1'b0;
    end else begin
      wptr      <= wptr_next;
      rptr      <= rptr_next;
      Count     <= count_next;
      Empty     <= (count_next == '0);
      Full      <= (count_next == PW'(DEPTH));
      ReadValid <= (count_next != '0);
      WriteDrop <= WriteEn && Full;
    end
  end

  // Storage is enable-loaded only; contents survive reset but become unreachable.
  always_ff @(posedge clk) begin
    if (!reset && push_c) begin
      mem[wptr[AW-1:0]] <= WriteData;
    end
  end

  assign ReadData = mem[rptr[AW-1:0]];

endmodule

// File: tb/tb_openhw_fifo_reader.sv
// Self-checking bench for openhw_fifo_reader: directed vector table, hand-written
// corner sequences, and a randomized run against a queue-based reference model.
module tb_openhw_fifo_reader;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             WriteEn;
  logic [WIDTH-1:0] WriteData;
  logic             Full;
  logic             WriteDrop;
  logic             ReadValid;
  logic             ReadReady;
  logic [WIDTH-1:0] ReadData;
  logic             Empty;
  logic [CW-1:0]    Count;

  int errors = 0;
  int checks = 0;

  // Reference model: the FIFO contents in order, plus the pending drop flag.
  logic [WIDTH-1:0] mq[$];
  bit               mdrop;

  typedef struct {
    bit         rst;
    bit         we;
    logic [7:0] wd;
    bit         rr;
    int         cnt;
    bit         full;
    bit         empty;
    bit         drop;
    logic [7:0] data;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  openhw_fifo_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .WriteEn   (WriteEn),
    .WriteData (WriteData),
    .Full      (Full),
    .WriteDrop (WriteDrop),
    .ReadValid (ReadValid),
    .ReadReady (ReadReady),
    .ReadData  (ReadData),
    .Empty     (Empty),
    .Count     (Count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model by the FIFO rules, then step past the edge.
  task automatic cycle(input bit rst, input bit we, input logic [WIDTH-1:0] wd, input bit rr);
    bit was_full;
    bit do_pop;
    reset     = rst;
    WriteEn   = we;
    WriteData = wd;
    ReadReady = rr;
    if (rst) begin
      mq.delete();
      mdrop = 1'b0;
    end else begin
      was_full = (mq.size() == DEPTH);
      do_pop   = rr && (mq.size() != 0);
      mdrop    = we && was_full;
      if (do_pop) void'(mq.pop_front());
      if (we && !was_full) mq.push_back(wd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"}, 32'(Count), 32'(mq.size()));
    check({tag, ".full"},  32'(Full),  32'(mq.size() == DEPTH));
    check({tag, ".empty"}, 32'(Empty), 32'(mq.size() == 0));
    check({tag, ".valid"}, 32'(ReadValid), 32'(mq.size() != 0));
    check({tag, ".drop"},  32'(WriteDrop), 32'(mdrop));
    if (mq.size() != 0) check({tag, ".data"}, 32'(ReadData), 32'(mq[0]));
    check({tag, ".inv_empty"}, 32'(Empty), 32'(Count == '0));
    check({tag, ".inv_full"},  32'(Full),  32'(Count == CW'(DEPTH)));
    check({tag, ".inv_valid"}, 32'(ReadValid), 32'(!Empty));
    check({tag, ".inv_range"}, 32'(Count <= CW'(DEPTH)), 32'(1));
    check({tag, ".inv_excl"},  32'(Full && Empty), 32'(0));
  endtask

  initial begin
    reset     = 1'b1;
    WriteEn   = 1'b0;
    WriteData = '0;
    ReadReady = 1'b0;
    mdrop     = 1'b0;

    // rst we  wd     rr cnt full empty drop data
    tbl.push_back('{1, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00});
    tbl.push_back('{0, 1, 8'h11, 0, 1, 0, 0, 0, 8'h11});
    tbl.push_back('{0, 1, 8'h22, 0, 2, 0, 0, 0, 8'h11});
    tbl.push_back('{0, 1, 8'h33, 0, 3, 0, 0, 0, 8'h11});
    tbl.push_back('{0, 1, 8'h44, 0, 4, 1, 0, 0, 8'h11});
    tbl.push_back('{0, 1, 8'hFF, 0, 4, 1, 0, 1, 8'h11});
    tbl.push_back('{0, 0, 8'h00, 0, 4, 1, 0, 0, 8'h11});
    tbl.push_back('{0, 1, 8'h55, 1, 3, 0, 0, 1, 8'h22});
    tbl.push_back('{0, 0, 8'h00, 0, 3, 0, 0, 0, 8'h22});
    tbl.push_back('{0, 0, 8'h00, 1, 2, 0, 0, 0, 8'h33});
    tbl.push_back('{0, 1, 8'h66, 1, 2, 0, 0, 0, 8'h44});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h66});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 1, 0, 8'h00});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 1, 0, 8'h00});
    tbl.push_back('{0, 1, 8'h77, 1, 1, 0, 0, 0, 8'h77});
    tbl.push_back('{0, 1, 8'h88, 0, 2, 0, 0, 0, 8'h77});
    tbl.push_back('{1, 1, 8'h99, 1, 0, 0, 1, 0, 8'h00});
    tbl.push_back('{0, 1, 8'h5A, 0, 1, 0, 0, 0, 8'h5A});

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      cycle(tbl[i].rst, tbl[i].we, tbl[i].wd, tbl[i].rr);
      check({tag, ".count"}, 32'(Count), 32'(tbl[i].cnt));
      check({tag, ".full"},  32'(Full),  32'(tbl[i].full));
      check({tag, ".empty"}, 32'(Empty), 32'(tbl[i].empty));
      check({tag, ".valid"}, 32'(ReadValid), 32'(!tbl[i].empty));
      check({tag, ".drop"},  32'(WriteDrop), 32'(tbl[i].drop));
      if (!tbl[i].empty) check({tag, ".data"}, 32'(ReadData), 32'(tbl[i].data));
    end

    // Fill to DEPTH, overflow once, then drain in order.
    cycle(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, WIDTH'(8'hA0 + i), 1'b0);
    check("fill.count", 32'(Count), 32'(4));
    check("fill.full",  32'(Full), 32'(1));
    cycle(1'b0, 1'b1, 8'hFF, 1'b0);
    check("ovf.drop",  32'(WriteDrop), 32'(1));
    check("ovf.count", 32'(Count), 32'(4));
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("ovf.drop_once", 32'(WriteDrop), 32'(0));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d.data", i), 32'(ReadData), 32'(8'hA0 + i));
      cycle(1'b0, 1'b0, '0, 1'b1);
    end
    check("drain.empty", 32'(Empty), 32'(1));
    check("drain.valid", 32'(ReadValid), 32'(0));

    // Steady stream: push and pop every cycle from empty; head lags input by one cycle.
    cycle(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, WIDTH'(8'h30 + i), 1'b1);
      check($sformatf("stream%0d.count", i), 32'(Count), 32'(1));
      check($sformatf("stream%0d.data", i), 32'(ReadData), 32'(8'h30 + i));
    end

    // Randomized traffic against the queue model, with occasional resets.
    cycle(1'b1, 1'b0, '0, 1'b0);
    for (int n = 0; n < 10000; n++) begin
      int unsigned wbias;
      int unsigned rbias;
      wbias = ((n / 500) % 2 == 0) ? 70 : 35;
      rbias = ((n / 500) % 2 == 0) ? 35 : 70;
      cycle($urandom_range(999) < 2,
            $urandom_range(99) < wbias,
            WIDTH'($urandom),
            $urandom_range(99) < rbias);
      check_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/openhw_fifo_reader.md
Name: openhw_fifo_reader

Overview:
- Synchronous single-clock FIFO; write side is a plain enable-qualified store, read side is a show-ahead valid/ready drain port.
- Decouples a producer that writes with a bare enable from a consumer that needs backpressure (e.g. bus response queues, trace buffers).
- Storage entries are enable-loaded registers, never reset.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, number of entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous active-high reset.
- WriteEn  input  1  push request for WriteData this cycle.
- WriteData  input  WIDTH  data to push.
- Full  output  1  registered; FIFO holds DEPTH entries.
- WriteDrop  output  1  registered; 1-cycle pulse, previous cycle's WriteEn was rejected.
- ReadValid  output  1  registered; head entry available (= !Empty).
- ReadReady  input  1  consumer accepts head this cycle.
- ReadData  output  WIDTH  head entry (show-ahead); don't-care while ReadValid=0.
- Empty  output  1  registered; FIFO holds 0 entries.
- Count  output  $clog2(DEPTH)+1  registered occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled on posedge clk.
- Reset values: write/read pointers 0, Count 0, Empty 1, Full 0, ReadValid 0, WriteDrop 0. Storage is not cleared.
- Pointers: $clog2(DEPTH)+1 bits each; the MSB is the wrap bit; the low bits index storage. Wrap-around from DEPTH-1 to 0 is natural binary overflow.
- Push accepted iff WriteEn && !Full (Full as registered at the start of the cycle). On accept: mem[wptr] <= WriteData, wptr++.
- No write pass-through: a push while Full is rejected even if a pop occurs in the same cycle. A rejected push sets WriteDrop=1 for the following cycle only.
- Pop iff ReadValid && ReadReady: rptr++. ReadReady while !ReadValid is ignored.
- ReadData = mem[rptr[low bits]], combinational from registered state, with no added latency.
- Latency: a word pushed at edge N is visible on ReadValid/ReadData in the cycle after edge N. No same-cycle bypass when empty.
- Count update: Count_next = Count + push - pop. Empty_next = (Count_next==0); Full_next = (Count_next==DEPTH).
- Simultaneous push and pop, neither empty nor full: both occur; Count unchanged; ordering preserved.
- Push while empty with ReadReady=1: push only; no pop.
- Push and pop while full: pop only; push dropped (WriteDrop next cycle); Count becomes DEPTH-1.
- Reset mid-operation: contents discarded; WriteEn and ReadReady in the reset cycle are ignored; WriteDrop=0 after reset.
- Invariants (bench asserts): Count<=DEPTH; Empty==(Count==0); Full==(Count==DEPTH); ReadValid==!Empty; never Full&&Empty.
- Data ordering: strict first-in first-out; no reordering and no duplication.

Test Plan:
- Reset, then push 0x11,0x22,0x33 on consecutive cycles with ReadReady=0 -> Count=3, ReadValid=1, ReadData=0x11, Full=0.
- Push 4 words (0xA0..0xA3) at DEPTH=4, then push 0xFF -> Full=1, Count=4, 0xFF not stored, WriteDrop=1 for exactly one cycle. Draining yields A0,A1,A2,A3, after which Empty=1.
- Steady stream: WriteEn=1 and ReadReady=1 for 20 cycles with incrementing data, starting from empty -> first cycle push only (Count 0->1), then Count holds at 1, output sequence equals input sequence delayed by 1 cycle, pointers wrap without loss.
- Full FIFO with push and pop in the same cycle -> head popped, push dropped, Count=3, Full=0, WriteDrop pulses.
- Reset asserted mid-stream with Count=2 and WriteEn=1 -> next cycle Count=0, Empty=1, ReadValid=0, WriteDrop=0. A subsequent push of 0x5A reads back as 0x5A.
- Random push/pop over 10k cycles against a scoreboard queue model -> all invariants hold and data matches in order.
